hamming_secded_decoder: RTL and testbench
=========================================

// Module: hamming_secded_decoder
// PURPOSE
//  - Receive-side partner of the team's 8-bit Hamming encoder.
//  - Checks and corrects an extended-Hamming (8,4) SECDED codeword: corrects any single-bit error and flags any double-bit error.
//  - Returns the 4 data bits with error status through a 2-stage valid/ready pipeline.
//  - Sits between the channel/storage read side and the consumer of the 4-bit data.
// PARAMETERS
//  CNT_W        8   width of each saturating error counter (counters exist only with the macro)
//  DED_ZERO     0   1: data_out forced to 4'h0 on a double error; 0: raw data bits passed through
// PORTS
//  clk          in   1      clock, rising edge
//  rstn         in   1      reset, asynchronous, active-low
//  in_valid     in   1      code_in valid
//  in_ready     out  1      decoder can accept code_in this cycle
//  code_in      in   8      codeword {P4,D4,D3,D2,P3,D1,P2,P1}, bit7..bit0
//  out_valid    out  1      data_out/status valid
//  out_ready    in   1      consumer accepts the result
//  data_out     out  4      {D4,D3,D2,D1}, corrected
//  err_single   out  1      single-bit error detected and corrected
//  err_double   out  1      uncorrectable double-bit error
//  err_pos      out  3      code_in bit index that was corrected (0..7); 0 when err_single=0
//  cnt_clr      in   1      (macro only) synchronous clear of both counters
//  corr_cnt     out  CNT_W  (macro only) number of err_single results delivered
//  uncorr_cnt   out  CNT_W  (macro only) number of err_double results delivered
// BEHAVIOUR
//  - Syndrome: s1=c0^c2^c4^c6; s2=c1^c2^c5^c6; s3=c3^c4^c5^c6; S={s3,s2,s1}.
//  - Overall parity: op = XOR of c7..c0 (a valid codeword has even parity).
//  - Classification:
//    - S=0, op=0 -> clean.
//    - S!=0, op=1 -> single error; flip c[S-1]; err_pos=S-1.
//    - S=0, op=1 -> single error in P4; data unchanged; err_pos=7.
//    - S!=0, op=0 -> double error; no correction; err_pos=0.
//  - err_single and err_double are never both 1.
//  - Pipeline:
//    - Stage 1 registers code_in, S and op.
//    - Stage 2 registers data_out and the flags.
//    - Latency 2 cycles from in accept to out_valid when unstalled.
//    - Throughput 1 word/cycle.
//  - Handshake:
//    - Pipeline advances when adv = ~out_valid | out_ready.
//    - in_ready = adv (combinational).
//    - Input is accepted when in_valid & in_ready.
//    - While out_valid=1 and out_ready=0, data_out and all status outputs are held stable and in_ready=0.
//    - Empty stage bubbles collapse on advance.
//  - Reset (async assert, sync deassert by the system):
//    - Both stage valids=0; out_valid=0; data_out=0; err_single=0; err_double=0; err_pos=0; counters=0.
//    - Reset mid-transfer drops in-flight words; no output is produced for them.
//  - 3 or more bit errors are outside the code's guarantee; the output follows the classification above, with no extra detection.
// CONFIGURATION
//  - Macro HAMMING_DEC_ERR_CNT_EN:
//    - Defined: ports cnt_clr, corr_cnt and uncorr_cnt exist.
//    - Counters increment on out_valid & out_ready with the matching flag.
//    - Counters saturate at 2**CNT_W-1 with no wrap.
//    - cnt_clr has priority over a same-cycle increment.
//  - Undefined: these three ports and the counter logic are absent; all other behaviour is identical.
// TESTING
//  - Clean words: 8'h55 -> data 4'hB, flags 0; 8'h00 -> 4'h0; 8'hFF -> 4'hF.
//  - Single data-bit error: 8'h45 (bit4 flipped) -> data 4'hB, err_single=1, err_pos=4.
//  - Single P4 error: 8'hD5 -> data 4'hB, err_single=1, err_pos=7; repeat for all 8 bits of 8'h55.
//  - Double error: 8'h56 (bits0,1 flipped) -> err_double=1, err_single=0; data 4'h0 when DED_ZERO=1.
//  - Backpressure: hold out_ready=0 for 3 cycles with 3 words offered -> in_ready=0 and output stable; release -> all words out in order, none lost or duplicated.
//  - Macro on: 3 corrected and 1 uncorrectable result -> corr_cnt=3, uncorr_cnt=1.
//    - CNT_W=2 with 5 corrected results -> corr_cnt saturates at 3.
//    - cnt_clr in the same cycle as an increment -> 0.
//    - rstn pulse mid-stream -> out_valid=0 next edge, counters=0.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
//   Receive-side partner of the 8-bit Hamming encoder. Checks an extended-Hamming (8,4)
//   SECDED codeword, corrects any single-bit error, flags any double-bit error and returns
//   the 4 data bits with status through a 2-stage valid/ready pipeline (latency 2, 1 word/cycle).
//
// Optional feature macro: HAMMING_DEC_ERR_CNT_EN
//   Adds parameter CNT_W and ports cnt_clr, corr_cnt, uncorr_cnt (saturating result counters).
//
// Parameters
//   CNT_W      width of each saturating error counter (macro builds only)
//   DED_ZERO   1: data_out forced to 4'h0 on a double error; 0: raw data bits passed through
//
// Ports
//   clk, rstn               clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       input handshake, code_in = {P4,D4,D3,D2,P3,D1,P2,P1}
//   out_valid/out_ready     output handshake
//   data_out                corrected {D4,D3,D2,D1}
//   err_single, err_double  corrected single error / uncorrectable double error
//   err_pos                 corrected code bit index (0..7), 0 when err_single=0
//   cnt_clr                 (macro) synchronous clear of both counters
//   corr_cnt, uncorr_cnt    (macro) delivered single / double error result counts
module hamming_secded_decoder #(
`ifdef HAMMING_DEC_ERR_CNT_EN
   parameter int unsigned CNT_W    = 8,
`endif
   parameter int unsigned DED_ZERO = 0
) (
   input  logic             clk,
   input  logic             rstn,
`ifdef HAMMING_DEC_ERR_CNT_EN
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       code_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       data_out,
   output logic             err_single,
   output logic             err_double,
   output logic [2:0]       err_pos
);

   logic       adv;
   logic [2:0] syn_in;
   logic       op_in;

   // Stage 1 state. Only the data bits of the codeword are needed downstream;
   // the parity bits matter solely through the syndrome and overall parity.
   logic       v1_q;
   logic [3:0] data1_q;
   logic [2:0] syn_q;
   logic       op_q;

   // Stage 2 (output) state.
   logic       out_valid_q;
   logic [3:0] data_q;
   logic       single_q;
   logic       double_q;
   logic [2:0] pos_q;

   logic [3:0] data_d;
   logic       single_d;
   logic       double_d;
   logic [2:0] pos_d;

   // Whole pipeline moves together; a stalled output freezes both stages.
   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   assign syn_in = {code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6],
                    code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6],
                    code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6]};
   assign op_in  = ^code_in;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q    <= 1'b0;
         data1_q <= 4'h0;
         syn_q   <= 3'd0;
         op_q    <= 1'b0;
      end else if (adv) begin
         v1_q <= in_valid;
         if (in_valid) begin
            data1_q <= {code_in[6], code_in[5], code_in[4], code_in[2]};
            syn_q   <= syn_in;
            op_q    <= op_in;
         end
      end
   end

   always_comb begin
      logic syn_err;
      syn_err  = (syn_q != 3'd0) && op_q;
      single_d = op_q;
      double_d = (syn_q != 3'd0) && !op_q;
      pos_d    = 3'd0;
      if (syn_err) begin
         pos_d = syn_q - 3'd1;
      end else if (op_q) begin
         pos_d = 3'd7;  // S=0 with odd parity: the error is P4 itself
      end
      // Data bits sit at code positions 2,4,5,6, i.e. syndromes 3,5,6,7.
      data_d = data1_q ^ {syn_err && (syn_q == 3'd7), syn_err && (syn_q == 3'd6),
                          syn_err && (syn_q == 3'd5), syn_err && (syn_q == 3'd3)};
      if (double_d && (DED_ZERO != 0)) begin
         data_d = 4'h0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         data_q      <= 4'h0;
         single_q    <= 1'b0;
         double_q    <= 1'b0;
         pos_q       <= 3'd0;
      end else if (adv) begin
         out_valid_q <= v1_q;
         if (v1_q) begin
            data_q   <= data_d;
            single_q <= single_d;
            double_q <= double_d;
            pos_q    <= pos_d;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign data_out   = data_q;
   assign err_single = single_q;
   assign err_double = double_q;
   assign err_pos    = pos_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
   logic             deliver;
   logic [CNT_W-1:0] corr_q;
   logic [CNT_W-1:0] uncorr_q;

   assign deliver = out_valid_q & out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else if (cnt_clr) begin
         corr_q   <= '0;
         uncorr_q <= '0;
      end else if (deliver) begin
         if (single_q && (corr_q != '1)) begin
            corr_q <= corr_q + CNT_W'(1);
         end
         if (double_q && (uncorr_q != '1)) begin
            uncorr_q <= uncorr_q + CNT_W'(1);
         end
      end
   end

   assign corr_cnt   = corr_q;
   assign uncorr_cnt = uncorr_q;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder
//   Directed bench for hamming_secded_decoder. Two instances share the stimulus:
//   dut (defaults) and dut_z (DED_ZERO=1, and CNT_W=2 when HAMMING_DEC_ERR_CNT_EN is set).
module tb_hamming_secded_decoder;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] code_in;

   logic       in_ready, out_valid, err_single, err_double;
   logic [3:0] data_out;
   logic [2:0] err_pos;
   logic       z_in_ready, z_out_valid, z_err_single, z_err_double;
   logic [3:0] z_data_out;
   logic [2:0] z_err_pos;
`ifdef HAMMING_DEC_ERR_CNT_EN
   logic       cnt_clr;
   logic [7:0] corr_cnt, uncorr_cnt;
   logic [1:0] z_corr_cnt, z_uncorr_cnt;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hamming_secded_decoder dut (
      .clk        (clk),
      .rstn       (rstn),
`ifdef HAMMING_DEC_ERR_CNT_EN
      .cnt_clr    (cnt_clr),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt),
`endif
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .code_in    (code_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .err_single (err_single),
      .err_double (err_double),
      .err_pos    (err_pos)
   );

   hamming_secded_decoder #(
`ifdef HAMMING_DEC_ERR_CNT_EN
      .CNT_W    (2),
`endif
      .DED_ZERO (1)
   ) dut_z (
      .clk        (clk),
      .rstn       (rstn),
`ifdef HAMMING_DEC_ERR_CNT_EN
      .cnt_clr    (cnt_clr),
      .corr_cnt   (z_corr_cnt),
      .uncorr_cnt (z_uncorr_cnt),
`endif
      .in_valid   (in_valid),
      .in_ready   (z_in_ready),
      .code_in    (code_in),
      .out_valid  (z_out_valid),
      .out_ready  (out_ready),
      .data_out   (z_data_out),
      .err_single (z_err_single),
      .err_double (z_err_double),
      .err_pos    (z_err_pos)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] d,
                          input logic s, input logic dd, input logic [2:0] p);
      chk({tag, ".valid"},  out_valid,  v);
      chk({tag, ".data"},   data_out,   d);
      chk({tag, ".single"}, err_single, s);
      chk({tag, ".double"}, err_double, dd);
      chk({tag, ".pos"},    err_pos,    p);
   endtask

   // Offer one word, then wait until it reaches the output (2 edges).
   task automatic send(input logic [7:0] c);
      in_valid = 1'b1;
      code_in  = c;
      #1;
      chk("send.in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] w;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      code_in   = 8'h00;
`ifdef HAMMING_DEC_ERR_CNT_EN
      cnt_clr   = 1'b0;
`endif
      #12;
      chk_out("reset", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
      chk("reset.in_ready", in_ready, 1'b1);
`ifdef HAMMING_DEC_ERR_CNT_EN
      chk("reset.corr", corr_cnt, 8'd0);
      chk("reset.uncorr", uncorr_cnt, 8'd0);
`endif
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      // Clean codewords
      send(8'h55); chk_out("clean55", 1'b1, 4'hB, 1'b0, 1'b0, 3'd0);
      send(8'h00); chk_out("clean00", 1'b1, 4'h0, 1'b0, 1'b0, 3'd0);
      send(8'hFF); chk_out("cleanFF", 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
      send(8'h87); chk_out("clean87", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);

      // Single errors
      send(8'h45); chk_out("single45", 1'b1, 4'hB, 1'b1, 1'b0, 3'd4);
      send(8'hD5); chk_out("singleP4", 1'b1, 4'hB, 1'b1, 1'b0, 3'd7);
      for (int i = 0; i < 8; i++) begin
         w = 8'h55 ^ (8'd1 << i);
         send(w);
         chk_out($sformatf("flip%0d", i), 1'b1, 4'hB, 1'b1, 1'b0, 3'(i));
         chk($sformatf("flip%0d.zdata", i), z_data_out, 4'hB);
      end

      // Double error: raw data on dut, zeroed on dut_z
      send(8'h56);
      chk_out("double56", 1'b1, 4'hB, 1'b0, 1'b1, 3'd0);
      chk("double56.zdata", z_data_out, 4'h0);
      chk("double56.zdouble", z_err_double, 1'b1);
      chk("double56.zsingle", z_err_single, 1'b0);

      // Back-to-back throughput
      in_valid = 1'b1; code_in = 8'h55;
      @(posedge clk); #1;
      code_in = 8'hFF;
      @(posedge clk); #1;
      chk_out("stream0", 1'b1, 4'hB, 1'b0, 1'b0, 3'd0);
      code_in = 8'h87;
      @(posedge clk); #1;
      chk_out("stream1", 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk_out("stream2", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      chk("stream.drain", out_valid, 1'b0);

      // Backpressure: 3 stalled cycles with a third word offered
      in_valid = 1'b1; code_in = 8'h55;
      @(posedge clk); #1;
      code_in = 8'hFF;
      @(posedge clk); #1;
      out_ready = 1'b0;
      code_in   = 8'h87;
      #1;
      chk("bp.in_ready_low", in_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk_out($sformatf("bp.hold%0d", k), 1'b1, 4'hB, 1'b0, 1'b0, 3'd0);
         chk($sformatf("bp.in_ready%0d", k), in_ready, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_rel", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_out("bp.out1", 1'b1, 4'hF, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      chk_out("bp.out2", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);
      @(posedge clk); #1;
      chk("bp.drain", out_valid, 1'b0);

`ifdef HAMMING_DEC_ERR_CNT_EN
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("cnt.clr_corr", corr_cnt, 8'd0);
      chk("cnt.clr_uncorr", uncorr_cnt, 8'd0);
      send(8'h45); send(8'hD5); send(8'h54); send(8'h56);
      @(posedge clk); #1;
      chk("cnt.corr3", corr_cnt, 8'd3);
      chk("cnt.uncorr1", uncorr_cnt, 8'd1);
      chk("cnt.zcorr3", z_corr_cnt, 2'd3);
      chk("cnt.zuncorr1", z_uncorr_cnt, 2'd1);
      send(8'h45); send(8'h45);
      @(posedge clk); #1;
      chk("cnt.corr5", corr_cnt, 8'd5);
      chk("cnt.zsat", z_corr_cnt, 2'd3);
      send(8'h45);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("cnt.clr_prio", corr_cnt, 8'd0);
      chk("cnt.clr_prio_u", uncorr_cnt, 8'd0);
      chk("cnt.clr_prio_z", z_corr_cnt, 2'd0);
`endif

      // Reset mid-stream: in-flight word must never appear
      send(8'h45);
      in_valid = 1'b1; code_in = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef HAMMING_DEC_ERR_CNT_EN
      chk("rst.pre_corr", corr_cnt, 8'd1);
`endif
      #2 rstn = 1'b0;
      #1;
      chk_out("rst.async", 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
`ifdef HAMMING_DEC_ERR_CNT_EN
      chk("rst.corr", corr_cnt, 8'd0);
      chk("rst.uncorr", uncorr_cnt, 8'd0);
`endif
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      chk("rst.drop1", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("rst.drop2", out_valid, 1'b0);
      chk("rst.data", data_out, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
